// File: rtl/alu_exec_unit.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers the operation; S2 registers the computed result and flags.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             bad_op,
    output logic [15:0]      op_count
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;
    localparam logic [3:0] OP_XOR = 4'd13;

    logic             s1_valid;
    logic [3:0]       s1_ctrl;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;

    logic             s2_load;
    logic             in_fire;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] c_result;
    logic             c_overflow;
    logic             c_bad;

    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    assign sum  = s1_a + s1_b;
    assign diff = s1_a - s1_b;

    always_comb begin
        c_result   = '0;
        c_overflow = 1'b0;
        c_bad      = 1'b0;
        case (s1_ctrl)
            OP_AND: c_result = s1_a & s1_b;
            OP_OR:  c_result = s1_a | s1_b;
            OP_ADD: begin
                c_result   = sum;
                c_overflow = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                c_result   = diff;
                c_overflow = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
            end
            // Direct signed compare so the answer stays right when a - b overflows
            OP_SLT: c_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_NOR: c_result = ~(s1_a | s1_b);
            OP_XOR: c_result = s1_a ^ s1_b;
            default: c_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ctrl  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ctrl <= alu_control;
                s1_a    <= op_a;
                s1_b    <= op_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            bad_op   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            result   <= c_result;
            zero     <= (c_result == '0);
            overflow <= c_overflow;
            bad_op   <= c_bad;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (in_fire && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
